// File: rtl/digit_scan_scheduler_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan scheduler.
package digit_scan_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [3:0] ANODES_OFF = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  function automatic logic [3:0] nibble_sel(input logic [15:0] word, input logic [1:0] idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/digit_scan_scheduler_slot_timer.sv
// Up-counter with synchronous clear; done is an exact compare against the terminal count.
module digit_scan_scheduler_slot_timer #(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic [CW-1:0] tc_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign done_o = (cnt_q == tc_i);

endmodule

// File: rtl/digit_scan_scheduler.sv
// Scans digits 3..0 with a blank dead-time per slot; new display data is taken only at frame boundaries.
module digit_scan_scheduler
  import digit_scan_scheduler_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 50000,
  parameter int unsigned DEAD        = 2000,
  parameter int          CW          = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [15:0] data_in_i,
  input  logic        data_valid_i,
  output logic        load_ack_o,
  output logic [3:0]  an_o,
  output logic [3:0]  seg_code_o,
  output logic [1:0]  digit_idx_o,
  output logic        frame_done_o
);

  localparam logic [1:0]    LAST_DIGIT = 2'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] TC_BLANK   = CW'(DEAD - 1);
  localparam logic [CW-1:0] TC_SHOW    = CW'(SLOT_CYCLES - DEAD - 1);

  state_t      state_q, state_d;
  logic [1:0]  digit_idx_q, digit_idx_d;
  logic [3:0]  seg_code_q, seg_code_d;
  logic [15:0] shadow_q, shadow_d;
  logic        load_ack_q, load_ack_d;
  logic        frame_done_q, frame_done_d;

  logic          timer_done;
  logic          timer_clear;
  logic [CW-1:0] timer_tc;

  // The timer restarts on every state change and stays parked while idle.
  assign timer_tc    = (state_q == SHOW) ? TC_SHOW : TC_BLANK;
  assign timer_clear = (state_d != state_q) || (state_q == IDLE);

  digit_scan_scheduler_slot_timer #(.CW(CW)) u_slot_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (timer_clear),
    .tc_i    (timer_tc),
    .done_o  (timer_done)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      digit_idx_q  <= LAST_DIGIT;
      seg_code_q   <= 4'h0;
      shadow_q     <= 16'h0000;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_idx_q  <= digit_idx_d;
      seg_code_q   <= seg_code_d;
      shadow_q     <= shadow_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    digit_idx_d  = digit_idx_q;
    seg_code_d   = seg_code_q;
    shadow_d     = shadow_q;
    load_ack_d   = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d     = BLANK;
          digit_idx_d = LAST_DIGIT;
          seg_code_d  = nibble_sel(shadow_q, LAST_DIGIT);
        end
      end
      BLANK: begin
        if (!enable_i) begin
          state_d     = IDLE;
          digit_idx_d = LAST_DIGIT;
        end else if (timer_done) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (!enable_i) begin
          state_d     = IDLE;
          digit_idx_d = LAST_DIGIT;
        end else if (timer_done) begin
          state_d = BLANK;
          if (digit_idx_q != 2'd0) begin
            digit_idx_d = digit_idx_q - 2'd1;
            seg_code_d  = nibble_sel(shadow_q, digit_idx_q - 2'd1);
          end else begin
            // Frame boundary: the only point where new data may replace the shadow.
            digit_idx_d  = LAST_DIGIT;
            frame_done_d = 1'b1;
            if (data_valid_i) begin
              shadow_d   = data_in_i;
              load_ack_d = 1'b1;
              seg_code_d = nibble_sel(data_in_i, LAST_DIGIT);
            end else begin
              seg_code_d = nibble_sel(shadow_q, LAST_DIGIT);
            end
          end
        end
      end
      default: begin
        state_d     = IDLE;
        digit_idx_d = LAST_DIGIT;
      end
    endcase
  end

  always_comb begin
    an_o = ANODES_OFF;
    if (state_q == SHOW) begin
      an_o[digit_idx_q] = 1'b0;
    end
  end

  assign seg_code_o   = seg_code_q;
  assign digit_idx_o  = digit_idx_q;
  assign load_ack_o   = load_ack_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_digit_scan_scheduler.sv
// Scoreboard bench for digit_scan_scheduler with SLOT_CYCLES=8, DEAD=2 (32-cycle frames).
module tb_digit_scan_scheduler;
  import digit_scan_scheduler_pkg::*;

  localparam int SLOT  = 8;
  localparam int DEADC = 2;
  localparam int LIT   = SLOT - DEADC;
  localparam int FRAME = 4 * SLOT;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [15:0] data_in_i;
  logic        data_valid_i;
  logic        load_ack_o;
  logic [3:0]  an_o;
  logic [3:0]  seg_code_o;
  logic [1:0]  digit_idx_o;
  logic        frame_done_o;

  always #5 clk_i = ~clk_i;

  digit_scan_scheduler #(.SLOT_CYCLES(SLOT), .DEAD(DEADC), .CW(16)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .data_in_i    (data_in_i),
    .data_valid_i (data_valid_i),
    .load_ack_o   (load_ack_o),
    .an_o         (an_o),
    .seg_code_o   (seg_code_o),
    .digit_idx_o  (digit_idx_o),
    .frame_done_o (frame_done_o)
  );

  typedef struct {
    logic [3:0] an;
    logic [3:0] seg;
    logic [1:0] idx;
    int         blank;
    int         lit;
  } rec_t;

  rec_t exp_q[$];
  bit   ack_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  bit   in_lit = 1'b0;
  int   run    = 0;
  int   epoch  = 0;
  rec_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_rec(input int d, input logic [3:0] seg, input int blank, input int lit);
    rec_t r;
    r.an    = ~(4'b0001 << d);
    r.seg   = seg;
    r.idx   = 2'(d);
    r.blank = blank;
    r.lit   = lit;
    exp_q.push_back(r);
  endtask

  task automatic push_frame(input logic [15:0] w);
    for (int d = 3; d >= 0; d--) begin
      push_rec(d, w[d*4 +: 4], DEADC, LIT);
    end
  endtask

  task automatic wait_ack(input int max);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!load_ack_o && n < max);
    if (!load_ack_o) check("ack_timeout", 32'(load_ack_o), 32'd1);
  endtask

  task automatic wait_fd(input int max);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!frame_done_o && n < max);
    if (!frame_done_o) check("frame_done_timeout", 32'(frame_done_o), 32'd1);
  endtask

  // Monitor: samples 2 time units after each rising edge, away from the negedge stimulus.
  initial begin : monitor
    int fd_cnt   = 0;
    bit fd_seen  = 1'b0;
    int fd_epoch = 0;
    forever begin
      @(posedge clk_i);
      #2;
      if (mon_en) begin
        check("an_onehot_low", 32'($countones(~an_o) <= 1), 32'd1);
        if (dut.state_q == BLANK) check("an_off_in_blank", 32'(an_o), 32'(ANODES_OFF));

        if (an_o == ANODES_OFF) begin
          if (in_lit) begin
            check("lit_len", 32'(run), 32'(cur.lit));
            in_lit = 1'b0;
            run    = 1;
          end else begin
            run++;
          end
        end else if (!in_lit) begin
          if (exp_q.size() == 0) begin
            check("digit_unexpected", 32'(an_o), 32'(ANODES_OFF));
            cur.an  = an_o;
            cur.seg = seg_code_o;
            cur.lit = LIT;
          end else begin
            cur = exp_q.pop_front();
            check("an_pattern", 32'(an_o), 32'(cur.an));
            check("seg_code", 32'(seg_code_o), 32'(cur.seg));
            check("digit_idx", 32'(digit_idx_o), 32'(cur.idx));
            check("blank_len", 32'(run), 32'(cur.blank));
          end
          in_lit = 1'b1;
          run    = 1;
        end else begin
          run++;
          check("an_stable", 32'(an_o), 32'(cur.an));
          check("seg_stable", 32'(seg_code_o), 32'(cur.seg));
        end

        fd_cnt++;
        if (frame_done_o) begin
          if (fd_seen && fd_epoch == epoch) check("frame_period", 32'(fd_cnt), 32'(FRAME));
          fd_seen  = 1'b1;
          fd_epoch = epoch;
          fd_cnt   = 0;
        end

        if (load_ack_o) begin
          if (ack_q.size() == 0) begin
            check("ack_unexpected", 32'(load_ack_o), 32'd0);
          end else begin
            void'(ack_q.pop_front());
            check("ack_with_frame_done", 32'(frame_done_o), 32'd1);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    reset_i      = 1'b1;
    enable_i     = 1'b1;
    data_in_i    = 16'h0000;
    data_valid_i = 1'b0;

    repeat (3) begin
      @(negedge clk_i);
      check("rst_an", 32'(an_o), 32'hF);
      check("rst_seg", 32'(seg_code_o), 32'h0);
      check("rst_idx", 32'(digit_idx_o), 32'd3);
      check("rst_ack", 32'(load_ack_o), 32'd0);
      check("rst_frame_done", 32'(frame_done_o), 32'd0);
    end

    // Frame 0 shows the reset shadow (zeros) while 4321 waits for the boundary.
    reset_i      = 1'b0;
    data_valid_i = 1'b1;
    data_in_i    = 16'h4321;
    push_frame(16'h0000);
    ack_q.push_back(1'b1);
    push_frame(16'h4321);
    mon_en = 1'b1;
    wait_ack(FRAME + 8);
    data_valid_i = 1'b0;

    // Request raised at cycle 5 of the 4321 frame; applies only from the next frame.
    repeat (5) @(negedge clk_i);
    data_valid_i = 1'b1;
    data_in_i    = 16'hABCD;
    ack_q.push_back(1'b1);
    push_frame(16'hABCD);
    wait_ack(FRAME + 8);
    data_valid_i = 1'b0;

    // Disrupted frame: digit 2 cut after 2 lit cycles, then 4 idle cycles and a restart.
    push_rec(3, 4'hA, DEADC, LIT);
    push_rec(2, 4'hB, DEADC, 2);
    push_rec(3, 4'hA, 6, LIT);
    push_rec(2, 4'hB, DEADC, LIT);
    push_rec(1, 4'hC, DEADC, LIT);
    push_rec(0, 4'hD, DEADC, LIT);

    // Cancelled request: valid held for 3 cycles mid-frame, never seen at a boundary.
    repeat (10) @(negedge clk_i);
    data_valid_i = 1'b1;
    data_in_i    = 16'h5555;
    repeat (3) @(negedge clk_i);
    data_valid_i = 1'b0;
    data_in_i    = 16'h0000;

    wait_fd(FRAME + 8);
    repeat (11) @(negedge clk_i);
    enable_i = 1'b0;
    epoch++;
    repeat (4) @(negedge clk_i);
    enable_i = 1'b1;

    for (int f = 0; f < 10; f++) push_frame(16'hABCD);

    n = 0;
    while ((exp_q.size() != 0 || in_lit) && n < 12 * FRAME + 40) begin
      @(negedge clk_i);
      n++;
    end
    check("expected_digits_consumed", 32'(exp_q.size()), 32'd0);
    check("expected_acks_consumed", 32'(ack_q.size()), 32'd0);
    mon_en = 1'b0;

    // Reset asserted while a digit is lit must blank the anodes on the next edge.
    n = 0;
    while (an_o == ANODES_OFF && n < 2 * SLOT) begin
      @(negedge clk_i);
      n++;
    end
    check("lit_before_reset", 32'(an_o != ANODES_OFF), 32'd1);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("midshow_rst_an", 32'(an_o), 32'hF);
    check("midshow_rst_seg", 32'(seg_code_o), 32'h0);
    check("midshow_rst_idx", 32'(digit_idx_o), 32'd3);
    check("midshow_rst_frame_done", 32'(frame_done_o), 32'd0);
    check("midshow_rst_ack", 32'(load_ack_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
